// File: rtl/fft_arith_pkg.sv
// Shared arithmetic helpers for the FFT butterfly datapath: width-generic
// signed range limits and the saturate-or-wrap result mapping.
package fft_arith_pkg;

  function automatic logic signed [63:0] max_pos(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] min_neg(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  // Caller keeps the low w bits; in wrap mode that is plain truncation.
  function automatic logic signed [63:0] sat_or_wrap(input logic signed [63:0] r,
                                                      input int w,
                                                      input logic sat);
    logic signed [63:0] res;
    res = r;
    if (sat) begin
      if (r > max_pos(w)) begin
        res = max_pos(w);
      end else if (r < min_neg(w)) begin
        res = min_neg(w);
      end else begin
        res = r;
      end
    end else begin
      res = r;
    end
    return res;
  endfunction

endpackage

// File: rtl/sat_trunc.sv
// Maps an exact (N+2)-bit signed result onto N bits, saturating or wrapping,
// and flags when the exact value does not fit in N bits.
module sat_trunc
  import fft_arith_pkg::*;
#(
  parameter int N   = 16,
  parameter int SAT = 1
) (
  input  logic [N+1:0] r_i,
  output logic [N-1:0] d_o,
  output logic         ovf_o
);

  logic signed [63:0] r_ext_s;
  logic signed [63:0] res_s;

  // Sign-extend, map to range, and detect overflow.
  always_comb begin
    r_ext_s = {{(62 - N){r_i[N+1]}}, r_i};
    res_s   = sat_or_wrap(r_ext_s, N, SAT != 0);
    d_o     = res_s[N-1:0];
    ovf_o   = (r_ext_s > max_pos(N)) || (r_ext_s < min_neg(N));
  end

endmodule

// File: rtl/sub3_pipe.sv
// Two-stage registered three-operand signed subtractor D = A - B - C with
// valid/ready on both sides and selectable saturation.
module sub3_pipe
  import fft_arith_pkg::*;
#(
  parameter int N   = 16,
  parameter int SAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [N-1:0] C,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] D,
  output logic         ovf
);

  logic         s1_valid_q, s1_valid_d;
  logic [N:0]   t_q, t_d;
  logic [N-1:0] c_q, c_d;
  logic         out_valid_q, out_valid_d;
  logic [N-1:0] d_q, d_d;
  logic         ovf_q, ovf_d;
  logic         s1_adv_s, s2_adv_s;
  logic [N+1:0] r_s;
  logic [N-1:0] d_sat_s;
  logic         ovf_sat_s;

  // Second subtraction is exact in N+2 bits.
  assign r_s = {t_q[N], t_q} - {{2{c_q[N-1]}}, c_q};

  sat_trunc #(.N(N), .SAT(SAT)) u_sat_trunc (
    .r_i   (r_s),
    .d_o   (d_sat_s),
    .ovf_o (ovf_sat_s)
  );

  // Handshake and next-state for both pipeline stages.
  always_comb begin
    s2_adv_s    = !out_valid_q || out_ready;
    s1_adv_s    = !s1_valid_q || s2_adv_s;
    s1_valid_d  = s1_valid_q;
    t_d         = t_q;
    c_d         = c_q;
    out_valid_d = out_valid_q;
    d_d         = d_q;
    ovf_d       = ovf_q;
    if (s1_adv_s) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        t_d = {A[N-1], A} - {B[N-1], B};
        c_d = C;
      end else begin
        t_d = t_q;
        c_d = c_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end
    if (s2_adv_s) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        d_d   = d_sat_s;
        ovf_d = ovf_sat_s;
      end else begin
        d_d   = d_q;
        ovf_d = ovf_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Pipeline registers with synchronous reset that drops in-flight data.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      t_q         <= '0;
      c_q         <= '0;
      out_valid_q <= 1'b0;
      d_q         <= '0;
      ovf_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      t_q         <= t_d;
      c_q         <= c_d;
      out_valid_q <= out_valid_d;
      d_q         <= d_d;
      ovf_q       <= ovf_d;
    end
  end

  assign in_ready  = s1_adv_s;
  assign out_valid = out_valid_q;
  assign D         = d_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_sub3_pipe.sv
// Scoreboard bench for sub3_pipe: one saturating and one wrapping instance
// share stimulus; expected results come from plain integer arithmetic.
module tb_sub3_pipe;

  localparam int N = 16;

  typedef struct {
    logic [15:0] d_sat;
    logic [15:0] d_wrap;
    logic        ovf;
    int          t_push;
    bit          chk_lat;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic signed [15:0] A = 16'sd0, B = 16'sd0, C = 16'sd0;
  logic               or_force = 1'b1;
  logic               rand_bp = 1'b0;
  logic               rnd_ready = 1'b1;
  logic               out_ready;
  logic               in_ready_s, in_ready_w;
  logic               out_valid_s, out_valid_w;
  logic [15:0]        d_s, d_w;
  logic               ovf_s, ovf_w;

  int   nvec = 0;
  int   nfail = 0;
  int   cyc = 0;
  bit   lat_mode = 1'b0;
  bit   rst_seen = 1'b0;
  bit   held = 1'b0;
  logic [15:0] held_ds, held_dw;
  logic        held_os, held_ow;
  exp_t q[$];

  assign out_ready = rand_bp ? rnd_ready : or_force;

  always #5 clk = ~clk;

  sub3_pipe #(.N(N), .SAT(1)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .A(A), .B(B), .C(C), .out_valid(out_valid_s), .out_ready(out_ready),
    .D(d_s), .ovf(ovf_s)
  );

  sub3_pipe #(.N(N), .SAT(0)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
    .A(A), .B(B), .C(C), .out_valid(out_valid_w), .out_ready(out_ready),
    .D(d_w), .ovf(ovf_w)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input int a, input int b, input int c);
    exp_t e;
    int r;
    r = a - b - c;
    e.ovf    = (r > 32767) || (r < -32768);
    e.d_wrap = r[15:0];
    if (r > 32767)       e.d_sat = 16'h7FFF;
    else if (r < -32768) e.d_sat = 16'h8000;
    else                 e.d_sat = r[15:0];
    e.t_push  = 0;
    e.chk_lat = 1'b0;
    return e;
  endfunction

  // Random backpressure source.
  always @(posedge clk) begin
    #1 rnd_ready = ($urandom_range(0, 9) < 7);
  end

  // Monitor: push on input transfer, pop and compare on output transfer.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      q.delete();
      held = 1'b0;
      rst_seen = 1'b1;
    end else begin
      if (rst_seen) begin
        chk("rst_out_valid", {31'd0, out_valid_s}, 32'd0);
        chk("rst_D", {16'd0, d_s}, 32'd0);
        chk("rst_ovf", {31'd0, ovf_s}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready_s}, 32'd1);
        rst_seen = 1'b0;
      end
      if (held) begin
        chk("hold_valid", {30'd0, out_valid_s, out_valid_w}, 32'd3);
        chk("hold_D_sat", {16'd0, d_s}, {16'd0, held_ds});
        chk("hold_D_wrap", {16'd0, d_w}, {16'd0, held_dw});
        chk("hold_ovf", {30'd0, ovf_s, ovf_w}, {30'd0, held_os, held_ow});
      end
      if (in_valid && in_ready_s) begin
        e = model(int'(A), int'(B), int'(C));
        e.t_push = cyc;
        e.chk_lat = lat_mode;
        q.push_back(e);
      end
      if (out_valid_s && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("D_sat", {16'd0, d_s}, {16'd0, e.d_sat});
          chk("ovf_sat", {31'd0, ovf_s}, {31'd0, e.ovf});
          chk("valid_wrap", {31'd0, out_valid_w}, 32'd1);
          chk("D_wrap", {16'd0, d_w}, {16'd0, e.d_wrap});
          chk("ovf_wrap", {31'd0, ovf_w}, {31'd0, e.ovf});
          if (e.chk_lat) chk("latency", cyc - e.t_push, 32'd2);
        end
      end
      held = out_valid_s && !out_ready;
      held_ds = d_s; held_dw = d_w; held_os = ovf_s; held_ow = ovf_w;
    end
  end

  task automatic send(input logic signed [15:0] a, input logic signed [15:0] b,
                      input logic signed [15:0] c);
    bit ok;
    ok = 1'b0;
    A = a; B = b; C = c; in_valid = 1'b1;
    for (int k = 0; k < 1000 && !ok; k++) begin
      @(negedge clk);
      if (in_ready_s) ok = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic logic signed [15:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return 16'sh7FFF;
      1:       return 16'sh8000;
      2:       return 16'shFFFF;
      3:       return 16'sh0001;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    bit drained;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    // Basic result and back-to-back stream with latency checked.
    lat_mode = 1'b1;
    send(16'sd100, 16'sd30, 16'sd20);
    idle(4);
    for (int i = 0; i < 6; i++) send(16'(i * 1000 - 2500), 16'(i * 7), 16'(-i * 300));
    idle(4);
    lat_mode = 1'b0;

    // Overflow corners in both directions.
    send(-16'sd32768, 16'sd1, 16'sd0);
    send(16'sd32767, -16'sd1, -16'sd1);
    send(-16'sd32768, 16'sd32767, 16'sd32767);
    send(16'sd32767, -16'sd32768, 16'sd0);
    idle(4);

    // Backpressure: five sets while the consumer stalls for four cycles.
    or_force = 1'b0;
    fork
      begin
        send(16'sd11, 16'sd1, 16'sd2);
        send(16'sd22, 16'sd3, 16'sd4);
        @(negedge clk);
        chk("bp_in_ready_low", {31'd0, in_ready_s}, 32'd0);
        @(posedge clk); #1;
        send(16'sd33, 16'sd5, 16'sd6);
        send(16'sd44, 16'sd7, 16'sd8);
        send(16'sd55, 16'sd9, 16'sd10);
      end
      begin
        repeat (4) @(posedge clk);
        #1 or_force = 1'b1;
      end
    join
    idle(5);

    // Reset with both stages full.
    or_force = 1'b0;
    send(16'sd1, 16'sd2, 16'sd3);
    send(16'sd4, 16'sd5, 16'sd6);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    or_force = 1'b1;
    idle(5);

    // Randomized valid/ready traffic.
    rand_bp = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      send(rnd_op(), rnd_op(), rnd_op());
    end
    rand_bp = 1'b0;
    or_force = 1'b1;

    drained = 1'b0;
    for (int k = 0; k < 1000 && !drained; k++) begin
      idle(1);
      if (q.size() == 0) drained = 1'b1;
    end
    chk("drain_empty", {31'd0, drained}, 32'd1);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/sub3_pipe.md
Name: sub3_pipe

Overview:
- Registered three-operand signed subtractor, D = A - B - C: the inverse-direction companion of the butterfly's three-operand summing stage.
- Used on the difference legs of the 32-point DIT FFT butterfly network.
- Two-stage pipeline with valid/ready handshake on both sides, so it tolerates downstream stalls.
- Selectable saturation or wrap on the N-bit result; overflow flag carried with each result.

Parameters:
- N, 16: operand and result width, two's-complement signed; N >= 4.
- SAT, 1: 1 = saturate the result to the N-bit signed range; 0 = wrap (keep the low N bits).

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  A/B/C valid this cycle.
- in_ready  output  1  block accepts the operand set this cycle.
- A  input  N  minuend, signed.
- B  input  N  first subtrahend, signed.
- C  input  N  second subtrahend, signed.
- out_valid  output  1  D/ovf hold a valid result.
- out_ready  input  1  consumer accepts the result this cycle.
- D  output  N  result, signed.
- ovf  output  1  the exact result fell outside the N-bit signed range (reported for both SAT settings).

Behaviour:
- Reset: synchronous, active-high. On any clk edge with rst=1:
  - s1_valid=0, out_valid=0, D=0, ovf=0, all pipeline data registers=0.
  - in_ready is 1 in the first cycle after reset is released.
  - A mid-operation reset discards all in-flight data; no partial output appears.
- Input handshake: transfer on a cycle where in_valid && in_ready. A, B and C are sampled only on transfer.
- Stage 1: registers T = sext(A) - sext(B), N+1 bits, plus sext(C).
- Stage 2: computes R = sext(T) - sext(C), N+2 bits, which is exact.
  - ovf = (R > 2^(N-1)-1) || (R < -2^(N-1)).
  - If SAT=1: D = the clamped value, 0x7F..F or 0x80..0 in N bits.
  - If SAT=0: D = R[N-1:0].
- Latency: 2 cycles from input transfer to out_valid when not stalled; throughput 1 result per cycle.
- Flow control:
  - s2_adv = !out_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv, which is purely registered state combined with out_ready; it does not depend on in_valid.
- Output hold: while out_valid && !out_ready, D, ovf and out_valid hold stable; stage 1 holds if it is full.
- Simultaneous input accept and output consume in the same cycle: both occur, with no bubble inserted.
- Stage 1 empty while stage 2 advances: out_valid falls the next cycle.
- No data loss or duplication: every accepted operand set produces exactly one result, in order.

Decomposition:
- Shared package fft_arith_pkg:
  - N-generic saturation limit constants, MAX_POS and MIN_NEG, as functions of width.
  - A sat_or_wrap function shared with the adder path.
- One natural sub-module, sat_trunc: maps N+2 bits to N bits plus ovf, with the SAT parameter. It is combinational and instantiated in stage 2.

Test Plan (N=16):
- Basic result: A=100, B=30, C=20, single transfer, out_ready=1 → out_valid exactly 2 cycles later, D=50, ovf=0; back-to-back inputs give one result per cycle, in order.
- Negative overflow:
  - SAT=1, A=-32768, B=1, C=0 → D=0x8000, ovf=1.
  - SAT=0, same operands → D=0x7FFF, ovf=1.
- Positive overflow, SAT=1: A=32767, B=-1, C=-1 (exact 32769) → D=0x7FFF, ovf=1. With SAT=0 → D=0x8001, ovf=1.
- Backpressure: stream 5 operand sets with out_ready=0 for 4 cycles.
  - in_ready drops after 2 are accepted.
  - D and ovf stay stable while stalled.
  - After out_ready=1, all 5 results emerge in order with no drop or duplicate.
- Reset mid-operation: assert rst for 1 cycle with both stages full → next cycle out_valid=0, D=0, ovf=0, in_ready=1; no stale result ever appears.
- Randomized valid/ready scoreboard with 10k sets against an exact reference model, for both SAT settings → zero mismatches.
